// File: rtl/hazard_fwd_unit.sv
// Hazard detection and operand forwarding for the five-stage pipeline.
// A shift-register scoreboard tracks in-flight destination registers
// behind ID. From that scoreboard the unit derives the stall, the flush
// and the forwarded rs1/rs2 values.
module hazard_fwd_unit #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned DEPTH      = 3,
  parameter int unsigned LOAD_AVAIL = 2,
  parameter int unsigned FWD_EN     = 1,
  parameter int unsigned CNT_W      = 16,
  localparam int unsigned SEL_W     = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               id_valid,
  input  logic [4:0]         id_rs1_addr,
  input  logic [4:0]         id_rs2_addr,
  input  logic               id_rs1_used,
  input  logic               id_rs2_used,
  input  logic [4:0]         id_rd_addr,
  input  logic               id_rf_wen,
  input  logic               id_is_load,
  input  logic [XLEN-1:0]    id_rs1_data,
  input  logic [XLEN-1:0]    id_rs2_data,
  input  logic [DEPTH*XLEN-1:0] stage_data,
  input  logic               ex_jump,
  output logic               stall,
  output logic               flush,
  output logic [SEL_W-1:0]   fwd_rs1_sel,
  output logic [SEL_W-1:0]   fwd_rs2_sel,
  output logic [XLEN-1:0]    id_rs1_fwd,
  output logic [XLEN-1:0]    id_rs2_fwd,
  output logic [CNT_W-1:0]   stall_cnt,
  output logic [CNT_W-1:0]   flush_cnt
);

  // Entry k holds the instruction k stages past ID (1 = EX).
  logic       sb_valid_q [1:DEPTH];
  logic [4:0] sb_rd_q    [1:DEPTH];
  logic       sb_load_q  [1:DEPTH];

  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

  logic [4:0]       src_addr [2];
  logic             src_used [2];
  logic [XLEN-1:0]  src_data [2];
  logic             src_hit  [2];
  logic             src_load [2];
  logic [SEL_W-1:0] src_k    [2];
  logic             src_haz  [2];
  logic [SEL_W-1:0] src_sel  [2];
  logic [XLEN-1:0]  src_fwd  [2];

  logic issue;

  // Youngest scoreboard match per source, hazard classification and operand mux.
  always_comb begin
    src_addr[0] = id_rs1_addr;
    src_addr[1] = id_rs2_addr;
    src_used[0] = id_rs1_used;
    src_used[1] = id_rs2_used;
    src_data[0] = id_rs1_data;
    src_data[1] = id_rs2_data;
    for (int s = 0; s < 2; s++) begin
      src_hit[s]  = 1'b0;
      src_load[s] = 1'b0;
      src_k[s]    = '0;
      // Scan oldest to youngest so the smallest matching k wins.
      for (int k = DEPTH; k >= 1; k--) begin
        if (src_used[s] && (src_addr[s] != 5'd0) && sb_valid_q[k] &&
            (sb_rd_q[k] == src_addr[s])) begin
          src_hit[s]  = 1'b1;
          src_load[s] = sb_load_q[k];
          src_k[s]    = SEL_W'(k);
        end
      end
      if (FWD_EN != 0) begin
        // Only a load whose data is not yet on stage_data blocks forwarding.
        src_haz[s] = src_hit[s] && src_load[s] && (32'(src_k[s]) < LOAD_AVAIL);
        src_sel[s] = reset ? '0 : src_k[s];
      end else begin
        // No write-through register file: every in-flight writer blocks.
        src_haz[s] = src_hit[s];
        src_sel[s] = '0;
      end
      src_fwd[s] = src_data[s];
      if (src_sel[s] != '0) begin
        src_fwd[s] = stage_data[(int'(src_sel[s]) - 1) * XLEN +: XLEN];
      end
    end
  end

  assign flush       = ~reset & ex_jump;
  assign stall       = ~reset & id_valid & ~ex_jump & (src_haz[0] | src_haz[1]);
  assign issue       = id_valid & ~stall & ~flush;
  assign fwd_rs1_sel = src_sel[0];
  assign fwd_rs2_sel = src_sel[1];
  assign id_rs1_fwd  = src_fwd[0];
  assign id_rs2_fwd  = src_fwd[1];
  assign stall_cnt   = stall_cnt_q;
  assign flush_cnt   = flush_cnt_q;

  // Scoreboard shift: ID result enters entry 1, bubble on stall/flush/idle.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 1; k <= DEPTH; k++) begin
        sb_valid_q[k] <= 1'b0;
        sb_rd_q[k]    <= 5'd0;
        sb_load_q[k]  <= 1'b0;
      end
    end else begin
      for (int k = DEPTH; k >= 2; k--) begin
        sb_valid_q[k] <= sb_valid_q[k-1];
        sb_rd_q[k]    <= sb_rd_q[k-1];
        sb_load_q[k]  <= sb_load_q[k-1];
      end
      sb_valid_q[1] <= issue & id_rf_wen & (id_rd_addr != 5'd0);
      sb_rd_q[1]    <= id_rd_addr;
      sb_load_q[1]  <= id_is_load;
    end
  end

  // Saturating stall/flush statistics.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + 1'b1;
      if (flush && (flush_cnt_q != '1)) flush_cnt_q <= flush_cnt_q + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Directed bench: one forwarding-mode and one stall-only instance share stimulus.
module tb_hazard_fwd_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        id_valid;
  logic [4:0]  id_rs1_addr, id_rs2_addr, id_rd_addr;
  logic        id_rs1_used, id_rs2_used, id_rf_wen, id_is_load;
  logic [31:0] id_rs1_data, id_rs2_data;
  logic [95:0] stage_data;
  logic        ex_jump;

  logic        stall1, flush1, stall0, flush0;
  logic [1:0]  s1_sel1, s2_sel1, s1_sel0, s2_sel0;
  logic [31:0] f1_1, f2_1, f1_0, f2_0;
  logic [15:0] scnt1, fcnt1, scnt0, fcnt0;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  hazard_fwd_unit #(.FWD_EN(1)) u_fwd (
    .clk(clk), .reset(reset), .id_valid(id_valid),
    .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .id_rd_addr(id_rd_addr), .id_rf_wen(id_rf_wen), .id_is_load(id_is_load),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
    .stage_data(stage_data), .ex_jump(ex_jump),
    .stall(stall1), .flush(flush1), .fwd_rs1_sel(s1_sel1), .fwd_rs2_sel(s2_sel1),
    .id_rs1_fwd(f1_1), .id_rs2_fwd(f2_1), .stall_cnt(scnt1), .flush_cnt(fcnt1)
  );

  hazard_fwd_unit #(.FWD_EN(0)) u_stall (
    .clk(clk), .reset(reset), .id_valid(id_valid),
    .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .id_rd_addr(id_rd_addr), .id_rf_wen(id_rf_wen), .id_is_load(id_is_load),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
    .stage_data(stage_data), .ex_jump(ex_jump),
    .stall(stall0), .flush(flush0), .fwd_rs1_sel(s1_sel0), .fwd_rs2_sel(s2_sel0),
    .id_rs1_fwd(f1_0), .id_rs2_fwd(f2_0), .stall_cnt(scnt0), .flush_cnt(fcnt0)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    #1;
  endtask

  task automatic set_idle;
    id_valid    = 1'b0;
    id_rs1_addr = 5'd0;
    id_rs2_addr = 5'd0;
    id_rs1_used = 1'b0;
    id_rs2_used = 1'b0;
    id_rd_addr  = 5'd0;
    id_rf_wen   = 1'b0;
    id_is_load  = 1'b0;
    ex_jump     = 1'b0;
  endtask

  task automatic do_reset;
    reset = 1'b1;
    set_idle();
    tick();
    reset = 1'b0;
  endtask

  // Issue a writer with no source operands, so it never stalls.
  task automatic issue_wr(input logic [4:0] rd, input logic ld);
    set_idle();
    id_valid   = 1'b1;
    id_rd_addr = rd;
    id_rf_wen  = 1'b1;
    id_is_load = ld;
    tick();
    set_idle();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    id_rs1_data = 32'hAAAA0001;
    id_rs2_data = 32'hBBBB0002;
    stage_data  = {32'h33333333, 32'h22222222, 32'h11111111};

    // Reset held two cycles with a jump and a valid dependent instruction.
    reset       = 1'b1;
    set_idle();
    ex_jump     = 1'b1;
    id_valid    = 1'b1;
    id_rs1_addr = 5'd5;
    id_rs1_used = 1'b1;
    id_rd_addr  = 5'd5;
    id_rf_wen   = 1'b1;
    #2;
    check_eq("rst_flush", {31'd0, flush1 | flush0}, 32'd0);
    check_eq("rst_stall", {31'd0, stall1 | stall0}, 32'd0);
    check_eq("rst_fwd", f1_1, 32'hAAAA0001);
    tick();
    check_eq("rst_flush2", {31'd0, flush1}, 32'd0);
    tick();
    reset = 1'b0;
    ex_jump = 1'b0;
    id_rf_wen = 1'b0;
    settle();
    check_eq("post_rst_sel", {30'd0, s1_sel1}, 32'd0);
    check_eq("post_rst_stall0", {31'd0, stall0}, 32'd0);
    check_eq("post_rst_scnt", {16'd0, scnt1}, 32'd0);
    check_eq("post_rst_fcnt", {16'd0, fcnt1}, 32'd0);

    // ALU result forwarded from EX.
    do_reset();
    issue_wr(5'd5, 1'b0);
    stage_data[31:0] = 32'h00001234;
    id_valid = 1'b1; id_rs1_addr = 5'd5; id_rs1_used = 1'b1;
    settle();
    check_eq("alu_sel", {30'd0, s1_sel1}, 32'd1);
    check_eq("alu_fwd", f1_1, 32'h00001234);
    check_eq("alu_stall", {31'd0, stall1}, 32'd0);
    check_eq("alu_stall_nofwd", {31'd0, stall0}, 32'd1);
    stage_data[31:0] = 32'h11111111;

    // Load-use: one bubble, then forward from MEM.
    do_reset();
    issue_wr(5'd7, 1'b1);
    id_valid = 1'b1; id_rs2_addr = 5'd7; id_rs2_used = 1'b1;
    settle();
    check_eq("ld_stall", {31'd0, stall1}, 32'd1);
    tick();
    stage_data[63:32] = 32'hBEEF0007;
    settle();
    check_eq("ld_stall_rel", {31'd0, stall1}, 32'd0);
    check_eq("ld_sel", {30'd0, s2_sel1}, 32'd2);
    check_eq("ld_fwd", f2_1, 32'hBEEF0007);
    check_eq("ld_scnt", {16'd0, scnt1}, 32'd1);
    set_idle();
    stage_data[63:32] = 32'h22222222;
    tick();
    check_eq("ld_scnt_hold", {16'd0, scnt1}, 32'd1);

    // Two writers to x3: youngest (EX) wins; rs2 hits x9 in MEM.
    do_reset();
    issue_wr(5'd3, 1'b0);
    issue_wr(5'd9, 1'b0);
    issue_wr(5'd3, 1'b0);
    id_valid = 1'b1;
    id_rs1_addr = 5'd3; id_rs1_used = 1'b1;
    id_rs2_addr = 5'd9; id_rs2_used = 1'b1;
    settle();
    check_eq("young_sel", {30'd0, s1_sel1}, 32'd1);
    check_eq("young_fwd", f1_1, 32'h11111111);
    check_eq("mem_sel", {30'd0, s2_sel1}, 32'd2);
    check_eq("mem_fwd", f2_1, 32'h22222222);

    // Forward from WB (entry DEPTH).
    do_reset();
    issue_wr(5'd12, 1'b0);
    tick();
    tick();
    id_valid = 1'b1; id_rs1_addr = 5'd12; id_rs1_used = 1'b1;
    settle();
    check_eq("wb_sel", {30'd0, s1_sel1}, 32'd3);
    check_eq("wb_fwd", f1_1, 32'h33333333);

    // x0 is never a dependency.
    do_reset();
    issue_wr(5'd0, 1'b0);
    id_valid = 1'b1; id_rs1_addr = 5'd0; id_rs1_used = 1'b1;
    settle();
    check_eq("x0_sel", {30'd0, s1_sel1}, 32'd0);
    check_eq("x0_fwd", f1_1, 32'hAAAA0001);
    check_eq("x0_stall", {31'd0, stall1 | stall0}, 32'd0);

    // Stall-only: jump flush beats the x1 hazard; squashed ID never enters sb[1].
    do_reset();
    issue_wr(5'd1, 1'b0);
    id_valid = 1'b1; id_rs1_addr = 5'd1; id_rs1_used = 1'b1;
    id_rd_addr = 5'd9; id_rf_wen = 1'b1; ex_jump = 1'b1;
    settle();
    check_eq("jmp_flush", {31'd0, flush0}, 32'd1);
    check_eq("jmp_stall", {31'd0, stall0}, 32'd0);
    tick();
    set_idle();
    id_valid = 1'b1; id_rs1_addr = 5'd9; id_rs1_used = 1'b1;
    settle();
    check_eq("jmp_bubble", {31'd0, stall0}, 32'd0);
    check_eq("jmp_flush_off", {31'd0, flush0}, 32'd0);
    check_eq("jmp_fcnt", {16'd0, fcnt0}, 32'd1);
    check_eq("jmp_scnt", {16'd0, scnt0}, 32'd0);

    // Stall-only: dependency on EX stalls DEPTH cycles.
    do_reset();
    issue_wr(5'd5, 1'b0);
    id_valid = 1'b1; id_rs1_addr = 5'd5; id_rs1_used = 1'b1;
    for (int i = 0; i < 3; i++) begin
      settle();
      check_eq($sformatf("il_stall%0d", i), {31'd0, stall0}, 32'd1);
      tick();
    end
    settle();
    check_eq("il_release", {31'd0, stall0}, 32'd0);
    check_eq("il_sel", {30'd0, s1_sel0}, 32'd0);
    check_eq("il_fwd", f1_0, 32'hAAAA0001);
    check_eq("il_scnt", {16'd0, scnt0}, 32'd3);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
